// File: rtl/rf_pkg.sv
// Shared types and sizing helpers for the register-file operand-fetch slice.
package rf_pkg;

  localparam int unsigned RF_NUM_REGS = 32;
  localparam int unsigned RF_DW       = 32;

  // Index width for a register file of num_regs entries (never narrower than 1 bit).
  function automatic int unsigned rf_idx_width(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  localparam int unsigned RF_RW = rf_idx_width(RF_NUM_REGS);

  typedef logic [RF_RW-1:0] reg_idx_t;

  typedef struct packed {
    logic               valid;
    reg_idx_t           rd;
    logic [RF_DW-1:0]   data;
  } rf_wb_t;

endpackage

// File: rtl/rf_bypass_slot.sv
// One operand slot: remembers which register was fetched, captures any
// writeback to that register that the read-first BRAM could not return,
// and selects the final operand value (x0 forced to zero).
module rf_bypass_slot
  import rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RW         = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  accept_i,
  input  logic                  hold_i,
  input  logic [RW-1:0]         req_rs_i,
  input  logic                  wb_we_i,
  input  logic [RW-1:0]         wb_rd_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic [DATA_WIDTH-1:0] rf_data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [RW-1:0]         rs_q,      rs_d;
  logic                  byp_q,     byp_d;
  logic [DATA_WIDTH-1:0] byp_val_q, byp_val_d;

  // Next-state: capture index on accept, track late writes while held, clear on flush.
  always_comb begin
    rs_d      = rs_q;
    byp_d     = byp_q;
    byp_val_d = byp_val_q;
    if (accept_i) begin
      rs_d = req_rs_i;
      // Read-first BRAM returns the old value when a write hits the same address.
      if (wb_we_i && (wb_rd_i == req_rs_i)) begin
        byp_d     = 1'b1;
        byp_val_d = wb_data_i;
      end else begin
        byp_d     = 1'b0;
      end
    end else if (hold_i) begin
      // BRAM output is frozen while stalled, so later writes must be captured here.
      if (wb_we_i && (wb_rd_i == rs_q)) begin
        byp_d     = 1'b1;
        byp_val_d = wb_data_i;
      end else begin
        byp_d     = byp_q;
      end
    end else begin
      byp_d = byp_q;
    end
    if (flush_i) begin
      byp_d = 1'b0;
    end else begin
      byp_d = byp_d;
    end
  end

  // Slot state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rs_q      <= {RW{1'b0}};
      byp_q     <= 1'b0;
      byp_val_q <= {DATA_WIDTH{1'b0}};
    end else begin
      rs_q      <= rs_d;
      byp_q     <= byp_d;
      byp_val_q <= byp_val_d;
    end
  end

  // Operand select: x0 reads zero, then bypass value, then BRAM data.
  always_comb begin
    data_o = rf_data_i;
    if (rs_q == {RW{1'b0}}) begin
      data_o = {DATA_WIDTH{1'b0}};
    end else if (byp_q) begin
      data_o = byp_val_q;
    end else begin
      data_o = rf_data_i;
    end
  end

endmodule

// File: rtl/rf_operand_fetch.sv
// Operand-fetch stage: issues rs1/rs2 reads to two read-first BRAM banks,
// mirrors writeback into both banks, and presents both operands with their
// tag one cycle after the request is accepted.
module rf_operand_fetch
  import rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned TAG_WIDTH  = 32,
  localparam int unsigned RW        = rf_idx_width(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [RW-1:0]         req_rs1_i,
  input  logic [RW-1:0]         req_rs2_i,
  input  logic [TAG_WIDTH-1:0]  req_tag_i,
  input  logic                  wb_valid_i,
  input  logic [RW-1:0]         wb_rd_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  rf1_en_o,
  output logic [RW-1:0]         rf1_addr_o,
  input  logic [DATA_WIDTH-1:0] rf1_data_i,
  output logic                  rf2_en_o,
  output logic [RW-1:0]         rf2_addr_o,
  input  logic [DATA_WIDTH-1:0] rf2_data_i,
  output logic                  rf_we_o,
  output logic [RW-1:0]         rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_rs1_data_o,
  output logic [DATA_WIDTH-1:0] out_rs2_data_o,
  output logic [TAG_WIDTH-1:0]  out_tag_o
);

  logic                 out_valid_q, out_valid_d;
  logic [TAG_WIDTH-1:0] tag_q,       tag_d;
  logic                 accept_s;
  logic                 hold_s;
  logic                 wb_we_s;

  // Handshake, read issue and writeback drive.
  always_comb begin
    req_ready_o = (!out_valid_q) || out_ready_i;
    accept_s    = req_valid_i && req_ready_o;
    hold_s      = out_valid_q && (!out_ready_i);
    // Enables stay low unless accepting so BRAM outputs hold during a stall.
    rf1_en_o    = accept_s;
    rf2_en_o    = accept_s;
    rf1_addr_o  = req_rs1_i;
    rf2_addr_o  = req_rs2_i;
    // x0 is never written, keeping BRAM content for x0 irrelevant.
    wb_we_s     = wb_valid_i && (wb_rd_i != {RW{1'b0}});
    rf_we_o     = wb_we_s;
    rf_waddr_o  = wb_rd_i;
    rf_wdata_o  = wb_data_i;
  end

  // Output valid/tag next-state; flush wins and drops a same-cycle accept.
  always_comb begin
    out_valid_d = out_valid_q;
    tag_d       = tag_q;
    if (accept_s) begin
      tag_d = req_tag_i;
    end else begin
      tag_d = tag_q;
    end
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept_s) begin
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output stage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      tag_q       <= {TAG_WIDTH{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      tag_q       <= tag_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_tag_o   = tag_q;

  rf_bypass_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .RW         (RW)
  ) u_slot_rs1 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .accept_i  (accept_s),
    .hold_i    (hold_s),
    .req_rs_i  (req_rs1_i),
    .wb_we_i   (wb_we_s),
    .wb_rd_i   (wb_rd_i),
    .wb_data_i (wb_data_i),
    .rf_data_i (rf1_data_i),
    .data_o    (out_rs1_data_o)
  );

  rf_bypass_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .RW         (RW)
  ) u_slot_rs2 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .accept_i  (accept_s),
    .hold_i    (hold_s),
    .req_rs_i  (req_rs2_i),
    .wb_we_i   (wb_we_s),
    .wb_rd_i   (wb_rd_i),
    .wb_data_i (wb_data_i),
    .rf_data_i (rf2_data_i),
    .data_o    (out_rs2_data_o)
  );

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Directed self-checking bench for rf_operand_fetch with a read-first BRAM model.
module tb_rf_operand_fetch;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          req_valid;
  logic          req_ready;
  logic [RW-1:0] req_rs1, req_rs2;
  logic [TW-1:0] req_tag;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          rf1_en, rf2_en, rf_we;
  logic [RW-1:0] rf1_addr, rf2_addr, rf_waddr;
  logic [DW-1:0] rf1_data, rf2_data, rf_wdata;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_rs1, out_rs2;
  logic [TW-1:0] out_tag;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] bank1 [32];
  logic [DW-1:0] bank2 [32];

  always #5 clk = ~clk;

  rf_operand_fetch #(.DATA_WIDTH(DW), .NUM_REGS(32), .TAG_WIDTH(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_tag_i(req_tag),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .rf1_en_o(rf1_en), .rf1_addr_o(rf1_addr), .rf1_data_i(rf1_data),
    .rf2_en_o(rf2_en), .rf2_addr_o(rf2_addr), .rf2_data_i(rf2_data),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_rs1_data_o(out_rs1), .out_rs2_data_o(out_rs2), .out_tag_o(out_tag)
  );

  // Read-first true dual-port BRAM pair: port A read, port B shared write.
  initial begin
    for (int i = 0; i < 32; i++) begin
      bank1[i] = $urandom;
      bank2[i] = $urandom;
    end
    bank1[0] = 32'hCAFE_0001;
    bank2[0] = 32'hCAFE_0002;
    rf1_data = 32'h0BAD_0001;
    rf2_data = 32'h0BAD_0002;
  end

  always @(posedge clk) begin
    if (rf1_en) rf1_data <= bank1[rf1_addr];
    if (rf2_en) rf2_data <= bank2[rf2_addr];
    if (rf_we) begin
      bank1[rf_waddr] <= rf_wdata;
      bank2[rf_waddr] <= rf_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 1'b0; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
  endtask

  task automatic write_reg(input logic [RW-1:0] rd, input logic [DW-1:0] d);
    wb_valid = 1'b1; wb_rd = rd; wb_data = d;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b want 1", req_ready); end
    tests++; if (out_tag !== 32'h0) begin fails++; $display("FAIL reset_tag: got %h want 0", out_tag); end
    tests++; if (out_rs1 !== 32'h0) begin fails++; $display("FAIL reset_rs1: got %h want 0", out_rs1); end
    tests++; if (rf1_en !== 1'b0) begin fails++; $display("FAIL reset_en: got %0b want 0", rf1_en); end
    tick(); tick();
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_read();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    #1;
    tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL wb_drive: got we=%0b a=%0d d=%h want 1/5/deadbeef", rf_we, rf_waddr, rf_wdata); end
    tick();
    wb_valid = 1'b0;
    tick();
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd0; req_tag = 32'h100;
    #1;
    tests++; if (rf1_en !== 1'b1 || rf1_addr !== 5'd5 || rf2_en !== 1'b1 || rf2_addr !== 5'd0) begin
      fails++; $display("FAIL read_issue: got en1=%0b a1=%0d en2=%0b a2=%0d want 1/5/1/0", rf1_en, rf1_addr, rf2_en, rf2_addr); end
    tick();
    req_valid = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
    tests++; if (out_rs1 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL basic_rs1: got %h want deadbeef", out_rs1); end
    tests++; if (out_rs2 !== 32'h0) begin fails++; $display("FAIL basic_rs2: got %h want 0", out_rs2); end
    tests++; if (out_tag !== 32'h100) begin fails++; $display("FAIL basic_tag: got %h want 100", out_tag); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_collision();
    write_reg(5'd7, 32'h5555_5555);
    req_valid = 1'b1; req_rs1 = 5'd7; req_rs2 = 5'd7; req_tag = 32'h2;
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234;
    tick();
    clear_inputs();
    #1;
    tests++; if (out_rs1 !== 32'h1234) begin fails++; $display("FAIL coll_rs1: got %h want 1234", out_rs1); end
    tests++; if (out_rs2 !== 32'h1234) begin fails++; $display("FAIL coll_rs2: got %h want 1234", out_rs2); end
    tests++; if (out_valid !== 1'b1 || out_tag !== 32'h2) begin
      fails++; $display("FAIL coll_vt: got v=%0b t=%h want 1/2", out_valid, out_tag); end
    tick();
  endtask

  task automatic test_hold();
    write_reg(5'd9, 32'h99);
    write_reg(5'd3, 32'h3333);
    req_valid = 1'b1; req_rs1 = 5'd3; req_rs2 = 5'd9; req_tag = 32'h33; out_ready = 1'b0;
    tick();
    // hold 1: new request pending, write x9=A
    req_rs1 = 5'd9; req_rs2 = 5'd0; req_tag = 32'h44;
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'hA;
    #1;
    tests++; if (rf2_en !== 1'b0 || rf1_en !== 1'b0 || req_ready !== 1'b0) begin
      fails++; $display("FAIL hold1_en: got en1=%0b en2=%0b rdy=%0b want 0/0/0", rf1_en, rf2_en, req_ready); end
    tests++; if (out_rs2 !== 32'h99) begin fails++; $display("FAIL hold1_rs2: got %h want 99", out_rs2); end
    tick();
    wb_data = 32'hB;
    #1;
    tests++; if (out_rs2 !== 32'hA) begin fails++; $display("FAIL hold2_rs2: got %h want a", out_rs2); end
    tick();
    wb_valid = 1'b0;
    #1;
    tests++; if (rf2_en !== 1'b0 || out_rs2 !== 32'hB) begin
      fails++; $display("FAIL hold3: got en2=%0b rs2=%h want 0/b", rf2_en, out_rs2); end
    tick();
    out_ready = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b1 || out_rs2 !== 32'hB || out_tag !== 32'h33 || out_rs1 !== 32'h3333) begin
      fails++; $display("FAIL release: got v=%0b rs1=%h rs2=%h t=%h want 1/3333/b/33", out_valid, out_rs1, out_rs2, out_tag); end
    tests++; if (req_ready !== 1'b1 || rf1_en !== 1'b1) begin
      fails++; $display("FAIL release_acc: got rdy=%0b en1=%0b want 1/1", req_ready, rf1_en); end
    tick();
    req_valid = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b1 || out_tag !== 32'h44 || out_rs1 !== 32'hB || out_rs2 !== 32'h0) begin
      fails++; $display("FAIL post_hold: got v=%0b t=%h rs1=%h rs2=%h want 1/44/b/0", out_valid, out_tag, out_rs1, out_rs2); end
    tick();
  endtask

  task automatic test_x0();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1;
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL x0_we: got %0b want 0", rf_we); end
    tick();
    wb_valid = 1'b0;
    req_valid = 1'b1; req_rs1 = 5'd0; req_rs2 = 5'd0; req_tag = 32'h9;
    tick();
    req_valid = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b1 || out_rs1 !== 32'h0 || out_rs2 !== 32'h0) begin
      fails++; $display("FAIL x0_read: got v=%0b rs1=%h rs2=%h want 1/0/0", out_valid, out_rs1, out_rs2); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] tags [3];
    tags[0] = 32'h1; tags[1] = 32'h2; tags[2] = 32'h3;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd3; req_tag = tags[i];
      #1;
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready%0d: got %0b want 1", i, req_ready); end
      tick();
      tests++; if (out_valid !== 1'b1 || out_tag !== tags[i]) begin
        fails++; $display("FAIL b2b_tag%0d: got v=%0b t=%h want 1/%h", i, out_valid, out_tag, tags[i]); end
    end
    req_valid = 1'b0;
    tests++; if (out_rs1 !== 32'hDEAD_BEEF || out_rs2 !== 32'h3333) begin
      fails++; $display("FAIL b2b_data: got rs1=%h rs2=%h want deadbeef/3333", out_rs1, out_rs2); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_flush_reset();
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd0; req_tag = 32'h55; flush = 1'b1;
    #1;
    tests++; if (req_ready !== 1'b1 || rf1_en !== 1'b1) begin
      fails++; $display("FAIL flush_hs: got rdy=%0b en=%0b want 1/1", req_ready, rf1_en); end
    tick();
    clear_inputs();
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_drop: got %0b want 0", out_valid); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_drop2: got %0b want 0", out_valid); end
    req_valid = 1'b1; req_tag = 32'h66; out_ready = 1'b0;
    tick();
    req_valid = 1'b0; flush = 1'b1;
    tests++; if (out_valid !== 1'b1 || out_tag !== 32'h66) begin
      fails++; $display("FAIL held66: got v=%0b t=%h want 1/66", out_valid, out_tag); end
    tick();
    flush = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_held: got %0b want 0", out_valid); end
    req_valid = 1'b1; req_tag = 32'h77;
    tick();
    req_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL pre_rst_valid: got %0b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_tag !== 32'h0 || out_rs1 !== 32'h0) begin
      fails++; $display("FAIL async_rst: got v=%0b t=%h rs1=%h want 0/0/0", out_valid, out_tag, out_rs1); end
    tick();
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_rst: got %0b want 0", out_valid); end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_basic_read();
    test_collision();
    test_hold();
    test_x0();
    test_back_to_back();
    test_flush_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_operand_fetch.md
Name: rf_operand_fetch

Overview:
- Operand-fetch stage that drives two register-file BRAM banks: bank 1 serves rs1 and bank 2 serves rs2.
- Both banks are true dual-port BRAMs in read-first mode. Port A is used for reads; port B is used for writeback, with the same write going to both banks.
- Accepts decoded source indices with a valid/ready handshake, issues the reads, and presents both operands one cycle later to execute.
- Handles x0, read-first write collisions and writes that land while the output is stalled.

Parameters:
- DATA_WIDTH, 32, operand/register width.
- NUM_REGS, 32, register count. Index width RW = $clog2(NUM_REGS).
- TAG_WIDTH, 32, opaque sideband (PC/uop) carried alongside the operands.

Ports:
- clk_i  in  1  clock; one clock.
- rst_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  drop the held result and any request accepted this cycle.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  stage can accept.
- req_rs1_i  in  RW  source index 1.
- req_rs2_i  in  RW  source index 2.
- req_tag_i  in  TAG_WIDTH  sideband.
- wb_valid_i  in  1  writeback valid.
- wb_rd_i  in  RW  writeback destination.
- wb_data_i  in  DATA_WIDTH  writeback data.
- rf1_en_o  out  1  bank 1 port A enable.
- rf1_addr_o  out  RW  bank 1 port A address.
- rf1_data_i  in  DATA_WIDTH  bank 1 port A read data.
- rf2_en_o  out  1  bank 2 port A enable.
- rf2_addr_o  out  RW  bank 2 port A address.
- rf2_data_i  in  DATA_WIDTH  bank 2 port A read data.
- rf_we_o  out  1  port B enable and write enable, both banks.
- rf_waddr_o  out  RW  port B address.
- rf_wdata_o  out  DATA_WIDTH  port B data.
- out_valid_o  out  1  operands valid.
- out_ready_i  in  1  execute accepts.
- out_rs1_data_o  out  DATA_WIDTH  operand 1.
- out_rs2_data_o  out  DATA_WIDTH  operand 2.
- out_tag_o  out  TAG_WIDTH  sideband.

Behaviour:
- Reset (async, rst_ni=0):
  - out_valid_o=0.
  - Captured indices, tag and bypass flags/values all 0.
  - Combinational outputs follow the inputs as defined below.
- Handshake:
  - req_ready_o = !out_valid_o || out_ready_i.
  - Accept = req_valid_i && req_ready_o.
  - Single-entry stage with full throughput, one operand pair per cycle.
- Read issue (combinational):
  - rf1_en_o = rf2_en_o = accept; rf1_addr_o = req_rs1_i; rf2_addr_o = req_rs2_i.
  - The enable is low at all other times, so BRAM outputs hold while stalled.
- Latency: operands valid the cycle after accept.
  - On accept: out_valid_o<=1, and rs1/rs2/tag are registered.
  - On out_ready_i without accept: out_valid_o<=0.
- Writeback (combinational):
  - rf_we_o = wb_valid_i && wb_rd_i!=0.
  - rf_waddr_o = wb_rd_i; rf_wdata_o = wb_data_i.
- Bypass, per operand k:
  - Accept cycle: if rf_we_o and wb_rd_i==req_rsk_i, set byp_k<=1 and byp_val_k<=wb_data_i. This is needed because read-first returns the old data. Otherwise byp_k<=0.
  - Held cycle (out_valid_o && !out_ready_i): if rf_we_o and wb_rd_i equals the captured rsk, set byp_k<=1 and byp_val_k<=wb_data_i. A later write to the same register overwrites the earlier one.
- Output mux, per operand: captured rs==0 -> 0; else byp_k -> byp_val_k; else rfk_data_i.
- x0: never written, always reads 0 regardless of BRAM content (BRAM init is random).
- Flush:
  - Forces out_valid_o<=0 and byp flags<=0 next cycle.
  - A request accepted in the same cycle is discarded (the handshake completes, the data is dropped).
  - Writeback is not affected by flush.
- Simultaneous consume and accept: the new request replaces the output seamlessly; bypass is evaluated against the new indices only.
- rs1==rs2: both operands are resolved independently to identical values.
- Reset mid-operation discards any pending result. BRAM contents are untouched (not reset).

Decomposition:
- Package rf_pkg: RW localparam helper, typedef reg_idx_t, typedef rf_wb_t {valid, rd, data}.
- One sub-module, rf_bypass_slot, instantiated twice (one per operand). It holds the captured index, byp flag and value, and contains the output mux.
- The top level contains the handshake, flush and port-drive logic.

Test Plan:
- Write x5=0xDEAD_BEEF, idle 1 cycle, then request rs1=5, rs2=0 -> the next cycle out_valid_o=1, out_rs1=0xDEADBEEF, out_rs2=0.
- Request rs1=7 with same-cycle wb x7=0x1234 -> out_rs1=0x1234, not the stale BRAM value.
- Accept rs2=9, hold out_ready_i=0 for 3 cycles with wb x9=0xA then x9=0xB -> on release, out_rs2=0xB, tag unchanged, rf2_en_o=0 during the hold.
- wb to x0 with 0xFFFF_FFFF -> rf_we_o=0; a later request for rs1=0 gives 0.
- Back-to-back requests tags 1, 2, 3 with out_ready_i=1 -> tags 1, 2, 3 on consecutive cycles, req_ready_o stays 1.
- Accept with flush_i=1, then assert rst_ni=0 while out_valid_o=1 -> no output appears after the flush; out_valid_o=0 immediately on reset.
